rptr_level_handler: RTL and testbench

RPTR_LEVEL_HANDLER -- requirements
Module: rptr_level_handler

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/gray2bin.sv | 19 +
 rtl/rptr_level_handler.sv | 82 ++++++++
 tb/tb_rptr_level_handler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer defaults and Gray/binary helper functions.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF   = 3;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended inputs decode correctly.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] r;
    r = g;
    for (int s = 1; s < 32; s = s << 1) begin
      r = r ^ (r >> s);
    end
    return r;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter for a ptr_width+1 bit pointer.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int ptr_width = PTR_WIDTH_DEF
) (
  input  logic [ptr_width:0] gray,
  output logic [ptr_width:0] bin
);

  always_comb begin
    bin = '0;
    bin[ptr_width] = gray[ptr_width];
    for (int i = ptr_width - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/rptr_level_handler.sv
// Read-side FIFO pointer, empty/level/almost-empty logic with write-pointer sync.
// Optional sticky underflow flag enabled by defining RPTR_UNDERFLOW_EN.
module rptr_level_handler
  import fifo_pkg::*;
#(
  parameter int ptr_width   = PTR_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  input  logic               r_en,
  input  logic [ptr_width:0] g_wptr_async,
  output logic               empty,
  output logic [ptr_width:0] b_rptr,
  output logic [ptr_width:0] g_rptr,
  output logic [ptr_width:0] rd_level,
  output logic               almost_empty,
  output logic               underflow
);

  localparam logic [ptr_width:0] AE_LVL = (ptr_width + 1)'(AE_THRESH);

  logic [ptr_width:0] sync_q [SYNC_STAGES];
  logic [ptr_width:0] g_wptr_sync;
  logic [ptr_width:0] b_wptr_sync;
  logic [ptr_width:0] b_rptr_next;
  logic [ptr_width:0] g_rptr_next;
  logic [ptr_width:0] level_next;
  logic               rd_inc;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= g_wptr_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign g_wptr_sync = sync_q[SYNC_STAGES-1];

  gray2bin #(.ptr_width(ptr_width)) u_wptr_g2b (
    .gray (g_wptr_sync),
    .bin  (b_wptr_sync)
  );

  // A read is accepted only when r_en is high and the FIFO is not empty.
  assign rd_inc      = r_en && !empty;
  assign b_rptr_next = b_rptr + {{ptr_width{1'b0}}, rd_inc};
  assign g_rptr_next = (b_rptr_next >> 1) ^ b_rptr_next;
  assign level_next  = b_wptr_sync - b_rptr_next;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr       <= '0;
      g_rptr       <= '0;
      empty        <= 1'b1;
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      b_rptr       <= b_rptr_next;
      g_rptr       <= g_rptr_next;
      empty        <= (g_rptr_next == g_wptr_sync);
      rd_level     <= level_next;
      almost_empty <= (level_next <= AE_LVL);
    end
  end

`ifdef RPTR_UNDERFLOW_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      underflow <= 1'b0;
    end else if (r_en && empty) begin
      underflow <= 1'b1;
    end
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_level_handler.sv
// Directed bench for rptr_level_handler (ptr_width=3, SYNC_STAGES=2, AE_THRESH=1).
module tb_rptr_level_handler;

  logic       rclk;
  logic       rrst;
  logic       r_en;
  logic [3:0] g_wptr_async;
  logic       empty;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic [3:0] rd_level;
  logic       almost_empty;
  logic       underflow;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];
  logic       exp_uf;

  rptr_level_handler #(
    .ptr_width   (3),
    .SYNC_STAGES (2),
    .AE_THRESH   (1)
  ) dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .r_en         (r_en),
    .g_wptr_async (g_wptr_async),
    .empty        (empty),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .rd_level     (rd_level),
    .almost_empty (almost_empty),
    .underflow    (underflow)
  );

  // Clock and reset-independent free-running clock.
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then sample away from it.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_b_rptr"}, 32'(b_rptr), 32'd0);
    check({tag, "_g_rptr"}, 32'(g_rptr), 32'd0);
    check({tag, "_rd_level"}, 32'(rd_level), 32'd0);
    check({tag, "_ae"}, 32'(almost_empty), 32'd1);
    check({tag, "_uf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef RPTR_UNDERFLOW_EN
    exp_uf = 1'b1;
`else
    exp_uf = 1'b0;
`endif
    rrst = 1'b1;
    r_en = 1'b0;
    g_wptr_async = 4'b0000;

    // Reset held for two edges.
    step();
    step();
    check_reset_vals("rst");

    // Single write visible after two synchronizer stages.
    rrst = 1'b0;
    g_wptr_async = 4'b0001;
    step();
    check("sync_k_empty", 32'(empty), 32'd1);
    step();
    check("sync_k1_empty", 32'(empty), 32'd1);
    check("sync_k1_level", 32'(rd_level), 32'd0);
    step();
    check("sync_k2_empty", 32'(empty), 32'd0);
    check("sync_k2_level", 32'(rd_level), 32'd1);
    check("sync_k2_ae", 32'(almost_empty), 32'd1);

    // Full FIFO (write pointer bin 8), then eight reads.
    g_wptr_async = 4'b1100;
    step(); step(); step();
    check("full_level", 32'(rd_level), 32'd8);
    check("full_empty", 32'(empty), 32'd0);
    check("full_ae", 32'(almost_empty), 32'd0);
    for (int i = 7; i >= 0; i--) exp_q.push_back(4'(i));
    r_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      logic [3:0] e;
      step();
      e = exp_q.pop_front();
      check($sformatf("rd%0d_level", i), 32'(rd_level), 32'(e));
      check($sformatf("rd%0d_b_rptr", i), 32'(b_rptr), 32'(i));
      check($sformatf("rd%0d_empty", i), 32'(empty), (i == 8) ? 32'd1 : 32'd0);
      check($sformatf("rd%0d_ae", i), 32'(almost_empty), (i >= 7) ? 32'd1 : 32'd0);
    end
    r_en = 1'b0;
    check("drain_g_rptr", 32'(g_rptr), 32'b1100);

    // Reads while empty are ignored.
    r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("uf%0d_b_rptr", i), 32'(b_rptr), 32'b1000);
    end
    r_en = 1'b0;
    step();
    check("uf_flag", 32'(underflow), 32'(exp_uf));
    check("uf_empty", 32'(empty), 32'd1);

    // Move read pointer to 1111 (write pointer bin 15 = gray 1000).
    g_wptr_async = 4'b1000;
    step(); step(); step();
    check("pre_wrap_level", 32'(rd_level), 32'd7);
    r_en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    r_en = 1'b0;
    check("pre_wrap_b_rptr", 32'(b_rptr), 32'b1111);
    check("pre_wrap_empty", 32'(empty), 32'd1);

    // Write pointer wraps to bin 1; two reads cross the 1111->0000 boundary.
    g_wptr_async = 4'b0001;
    step(); step(); step();
    check("wrap_level", 32'(rd_level), 32'd2);
    check("wrap_ae", 32'(almost_empty), 32'd0);
    r_en = 1'b1;
    step();
    check("wrap_rd1_b_rptr", 32'(b_rptr), 32'b0000);
    check("wrap_rd1_level", 32'(rd_level), 32'd1);
    check("wrap_rd1_empty", 32'(empty), 32'd0);
    step();
    r_en = 1'b0;
    check("wrap_rd2_b_rptr", 32'(b_rptr), 32'b0001);
    check("wrap_rd2_g_rptr", 32'(g_rptr), 32'b0001);
    check("wrap_rd2_empty", 32'(empty), 32'd1);
    check("wrap_rd2_level", 32'(rd_level), 32'd0);

    // Last entry read on the same edge a new write pointer becomes visible.
    g_wptr_async = 4'b0011;
    step(); step(); step();
    check("sim_pre_level", 32'(rd_level), 32'd1);
    g_wptr_async = 4'b0010;
    step();
    step();
    r_en = 1'b1;
    step();
    r_en = 1'b0;
    check("sim_b_rptr", 32'(b_rptr), 32'd2);
    check("sim_empty", 32'(empty), 32'd0);
    check("sim_level", 32'(rd_level), 32'd1);

    // Reset wins over a concurrent read with five entries pending.
    g_wptr_async = 4'b0100;
    step(); step(); step();
    check("prerst_level", 32'(rd_level), 32'd5);
    rrst = 1'b1;
    r_en = 1'b1;
    step();
    check_reset_vals("rst_rd");
    rrst = 1'b0;
    r_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
